// File: rtl/uart_pkg.sv
// Shared types and helpers for the stream UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clock cycles from the accept edge until the FSM is back in IDLE.
    function automatic int uart_frame_cycles(input int clk_div, input int parity, input int stop_bits);
        return clk_div * (9 + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled, ticks on the last cycle of each bit.
module uart_bit_timer #(
    parameter int CLK_DIV = 868
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr || !en || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/stream_uart_tx.sv
// Stream-to-UART serializer: accepts one byte per frame over valid/ready and
// shifts it out LSB-first with optional parity and 1 or 2 stop bits.
module stream_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 868,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       itvalid,
    output logic       itready,
    input  logic [7:0] itdata,
    output logic       o_uart_tx,
    output logic       o_busy
);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("stream_uart_tx: CLK_DIV must be >= 2");
    end
    if (PARITY > 2 || PARITY < 0) begin : g_bad_par
        $error("stream_uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("stream_uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam logic STOP_LAST = (STOP_BITS == 2);

    uart_tx_state_t state;
    logic [7:0]     shreg;
    logic [2:0]     bitcnt;
    logic           stopcnt;
    logic           par_bit;
    logic           hs;
    logic           tick;

    assign itready = rstn & (state == IDLE);
    assign hs      = itvalid & itready;

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk  (clk),
        .rstn (rstn),
        .clr  (hs),
        .en   (state != IDLE),
        .tick (tick)
    );

    // Line value for each state is registered on the edge that enters it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            stopcnt   <= 1'b0;
            par_bit   <= 1'b0;
            o_uart_tx <= 1'b1;
            o_busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    shreg     <= itdata;
                    par_bit   <= (PARITY == PARITY_ODD) ? ~^itdata : ^itdata;
                    o_uart_tx <= 1'b0;
                    o_busy    <= 1'b1;
                    state     <= START;
                end
                START: if (tick) begin
                    o_uart_tx <= shreg[0];
                    shreg     <= shreg >> 1;
                    bitcnt    <= '0;
                    state     <= DATA;
                end
                DATA: if (tick) begin
                    if (bitcnt == 3'd7) begin
                        if (PARITY != PARITY_NONE) begin
                            o_uart_tx <= par_bit;
                            state     <= PAR;
                        end else begin
                            o_uart_tx <= 1'b1;
                            stopcnt   <= 1'b0;
                            state     <= STOP;
                        end
                    end else begin
                        o_uart_tx <= shreg[0];
                        shreg     <= shreg >> 1;
                        bitcnt    <= bitcnt + 3'd1;
                    end
                end
                PAR: if (tick) begin
                    o_uart_tx <= 1'b1;
                    stopcnt   <= 1'b0;
                    state     <= STOP;
                end
                STOP: if (tick) begin
                    if (stopcnt == STOP_LAST) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        stopcnt <= 1'b1;
                    end
                end
                default: begin
                    o_uart_tx <= 1'b1;
                    o_busy    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_uart_tx.sv
// Directed bench for stream_uart_tx: four parameterisations side by side,
// per-cycle line capture decoded against a scoreboard of accepted bytes.
module tb_stream_uart_tx;

    localparam int N = 4;
    localparam int DIV  [N] = '{4, 4, 4, 5};
    localparam int PARM [N] = '{0, 1, 2, 0};
    localparam int SB   [N] = '{1, 1, 1, 2};
    localparam int FEXP [N] = '{40, 44, 44, 55};

    logic           clk  = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   v    = '0;
    logic [7:0]     d [N];
    wire  [N-1:0]   rdy, tx, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        stream_uart_tx #(.CLK_DIV(DIV[g]), .PARITY(PARM[g]), .STOP_BITS(SB[g])) u_dut (
            .clk       (clk),
            .rstn      (rstn),
            .itvalid   (v[g]),
            .itready   (rdy[g]),
            .itdata    (d[g]),
            .o_uart_tx (tx[g]),
            .o_busy    (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer byte b to DUT g (called at a negedge), capture F+1 cycles after accept
    // and check the whole line waveform, itready/o_busy timing and the decoded byte.
    task automatic frame(input int g, input logic [7:0] b, input bit keep_v,
                         input bit scramble, output int hcyc);
        logic       tx_s   [0:127];
        logic       rdy_s  [0:127];
        logic       busy_s [0:127];
        logic       bits   [0:15];
        logic [7:0] exp, got;
        int f, dv, n, idx, mism, nrdy, nbusy;
        f  = FEXP[g];
        dv = DIV[g];
        hcyc = 0;
        d[g] = b;
        v[g] = 1'b1;
        n = 0;
        while (!rdy[g] && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 500), 32'd1);
        if (n >= 500) return;
        @(posedge clk);
        #1 hcyc = cyc;
        sb.push_back(b);
        if (!keep_v && !scramble) v[g] = 1'b0;
        for (int i = 0; i <= f; i++) begin
            @(negedge clk);
            tx_s[i]   = tx[g];
            rdy_s[i]  = rdy[g];
            busy_s[i] = busy[g];
            if (scramble) begin
                if (i == f) v[g] = 1'b0;
                else        d[g] = 8'($urandom);
            end
        end
        exp = sb.pop_front();
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[1+k] = exp[k];
        idx = 9;
        if (PARM[g] == 1) begin bits[9] = ~^exp; idx = 10; end
        if (PARM[g] == 2) begin bits[9] = ^exp;  idx = 10; end
        for (int s = 0; s < SB[g]; s++) bits[idx+s] = 1'b1;
        mism = 0; nrdy = 0; nbusy = 0;
        for (int i = 0; i < f; i++) begin
            if (tx_s[i] !== bits[i/dv]) mism++;
            if (rdy_s[i] === 1'b0) nrdy++;
            if (busy_s[i] === 1'b1) nbusy++;
        end
        for (int k = 0; k < 8; k++) got[k] = tx_s[(1+k)*dv + dv/2];
        chk("start_on_accept_edge", 32'(tx_s[0]), 32'd0);
        chk("data_byte", 32'(got), 32'(exp));
        if (PARM[g] != 0) chk("parity_bit", 32'(tx_s[9*dv + dv/2]), 32'(bits[9]));
        chk("waveform_mismatches", 32'(mism), 32'd0);
        chk("itready_low_cycles", 32'(nrdy), 32'(f));
        chk("busy_cycles", 32'(nbusy), 32'(f));
        chk("itready_at_F", 32'(rdy_s[f]), 32'd1);
        chk("busy_at_F", 32'(busy_s[f]), 32'd0);
        chk("idle_high_at_F", 32'(tx_s[f]), 32'd1);
    endtask

    initial begin
        int h0, h1, h2;
        for (int g = 0; g < N; g++) d[g] = 8'h00;
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk("reset_tx", 32'(tx[g]), 32'd1);
            chk("reset_busy", 32'(busy[g]), 32'd0);
            chk("reset_ready", 32'(rdy[g]), 32'd0);
        end
        rstn = 1'b1;
        repeat (6) @(negedge clk);

        // Single byte, no parity
        frame(0, 8'hA5, 1'b0, 1'b0, h0);
        repeat (3) @(negedge clk);

        // Back-to-back with itvalid held high
        frame(0, 8'h00, 1'b1, 1'b0, h0);
        frame(0, 8'hFF, 1'b1, 1'b0, h1);
        frame(0, 8'h55, 1'b0, 1'b0, h2);
        chk("b2b_gap_1", 32'(h1 - h0), 32'd41);
        chk("b2b_gap_2", 32'(h2 - h1), 32'd41);
        @(negedge clk);

        // Odd and even parity
        frame(1, 8'h07, 1'b0, 1'b0, h0);
        frame(2, 8'h07, 1'b0, 1'b0, h0);
        frame(2, 8'hC3, 1'b0, 1'b0, h0);

        // Two stop bits, CLK_DIV=5
        frame(3, 8'h5A, 1'b0, 1'b0, h0);
        @(negedge clk);

        // Reset during DATA bit 3 (byte bit3 = 0)
        d[0] = 8'hF7;
        v[0] = 1'b1;
        @(posedge clk);
        #1 v[0] = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre_reset_bit3_low", 32'(tx[0]), 32'd0);
        chk("pre_reset_busy", 32'(busy[0]), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("async_reset_tx", 32'(tx[0]), 32'd1);
        chk("async_reset_busy", 32'(busy[0]), 32'd0);
        chk("async_reset_ready", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(rdy[0]), 32'd1);
        chk("post_reset_idle", 32'(tx[0]), 32'd1);
        frame(0, 8'h3C, 1'b0, 1'b0, h0);

        // itdata churn after accept, itvalid kept high through the frame
        frame(0, 8'h81, 1'b0, 1'b1, h0);
        @(negedge clk);
        chk("no_extra_accept_ready", 32'(rdy[0]), 32'd1);
        chk("no_extra_accept_busy", 32'(busy[0]), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stream_uart_tx.md
Name: stream_uart_tx

Overview:
Drains a byte stream (valid/ready handshake, same semantics as the team's stream FIFOs) and serializes each byte onto a UART TX line. It sits downstream of a stream FIFO output and carries NFC frame/debug bytes to a host. The divider is fixed at elaboration, and the frame format is 8 data bits LSB-first with optional parity.

Parameters:
CLK_DIV, 868, clock cycles per UART bit (≥2); 868 = 115200 baud at 100 MHz
PARITY, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock
rstn  input  1  reset: asynchronous assert, active-low
itvalid  input  1  input byte valid
itready  output  1  block can accept a byte this cycle
itdata  input  8  input byte
o_uart_tx  output  1  UART TX line, idle high, registered
o_busy  output  1  frame in progress (state != IDLE), registered

Behaviour:
- Reset: asynchronous, active-low.
  - While rstn=0: o_uart_tx=1, o_busy=0, itready=0, state=IDLE, bit counter=0, divider=0.
  - Reset asserted mid-frame aborts the frame immediately. The line goes high and no partial byte is resumed.
- itready = rstn & (state==IDLE). This is combinational from registered state and never depends on itvalid.
- Handshake:
  - A byte is taken on a rising edge with itvalid&itready. itdata is latched into a shift register.
  - Parity is computed from the latched byte at the same edge.
  - itvalid may drop or itdata may change afterwards with no effect.
- FSM: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
  - Each bit state lasts exactly CLK_DIV cycles, timed by a divider counting 0..CLK_DIV-1.
  - o_uart_tx changes on the edge that enters the state:
    - START: 0.
    - DATA: shift-reg LSB, shifted right each bit; 8 bits, counter 0..7.
    - PARITY: odd = ~^byte, even = ^byte.
    - STOP: 1 for STOP_BITS*CLK_DIV cycles.
- Latency: o_uart_tx falls on the same edge as the handshake.
  - Frame length F = CLK_DIV*(1+8+(PARITY!=0)+STOP_BITS) cycles.
  - State returns to IDLE at handshake edge + F, and itready rises in that cycle.
  - Back-to-back frames therefore repeat every F+1 cycles: one idle-high clock between the last stop bit and the next start bit.
- o_busy is high from the handshake edge to handshake edge + F.
- Width rules: divider is $clog2(CLK_DIV) bits, with wrap compare against CLK_DIV-1 (no overflow at non-power-of-2). Bit counter is 3 bits; stop counter is 1 bit.
- itvalid held high with no data ready upstream is legal. Nothing is accepted while state != IDLE.
- Static checks: CLK_DIV<2, PARITY>2 or STOP_BITS outside {1,2} is an elaboration error.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_tx_state_t.
  - localparams PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2.
  - function uart_frame_cycles(CLK_DIV, PARITY, STOP_BITS) for bench and RTL use.
- One natural sub-module: uart_bit_timer.
  - Divider with clear-on-load input and a one-cycle tick output on the last cycle of each bit.
  - Reused later by the matching stream UART receiver.

Test Plan:
- Single byte (CLK_DIV=4, PARITY=0, STOP=1): send 8'hA5 at cycle 10.
  - o_uart_tx bits sampled mid-bit = 0,1,0,1,0,0,1,0,1,1.
  - itready low cycles 10–49, high again at cycle 50.
- Back-to-back: itvalid held high with bytes 8'h00, 8'hFF, 8'h55.
  - Three handshakes at cycles t, t+41, t+82.
  - Start edges 41 cycles apart, exactly one idle-high cycle between frames.
- Parity (PARITY=1 odd, then PARITY=2 even): byte 8'h07 gives a parity bit of 0 (odd) / 1 (even).
  - Frame length 44 cycles at CLK_DIV=4.
- STOP_BITS=2, CLK_DIV=5: frame = 55 cycles, and o_uart_tx is high for the last 10 of them.
- Reset mid-frame: assert rstn=0 during the DATA bit 3 low period.
  - o_uart_tx=1 and o_busy=0 asynchronously, before the next clock.
  - After release, itready=1 and the next byte 8'h3C transmits a complete, correct frame.
- Handshake stability: itdata changed every cycle after the accept edge for 8'h81.
  - Transmitted bits still encode 8'h81, and no extra handshake occurs while o_busy=1.
